// File: rtl/proc_mem_responder_if.sv
// Processor memory bus: byte address, write strobe/data and combinational read data.
interface proc_mem_responder_if;
    logic [31:0] Bus_Address;
    logic        Bus_WriteEnable;
    logic [31:0] Bus_WriteData;
    logic [31:0] Bus_ReadData;

    modport master (output Bus_Address, Bus_WriteEnable, Bus_WriteData, input Bus_ReadData);
    modport slave  (input Bus_Address, Bus_WriteEnable, Bus_WriteData, output Bus_ReadData);
endinterface

// File: rtl/proc_mem_responder.sv
// Memory bus target: zero-wait-state word RAM plus an MMIO window (LED, synchronised
// switches, compare timer, sticky W1C status).
module proc_mem_responder #(
    parameter int          RAM_AWIDTH = 10,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000,
    parameter int          IO_WIDTH   = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    proc_mem_responder_if.slave bus,
    input  logic [IO_WIDTH-1:0] Sw_In,
    output logic [IO_WIDTH-1:0] Led_Out,
    output logic                Timer_Irq,
    output logic                Err_Flag
);
    localparam logic [32:0] RAM_BYTES = 33'(4) << RAM_AWIDTH;

    localparam logic [2:0] OFF_LED   = 3'd0;
    localparam logic [2:0] OFF_SW    = 3'd1;
    localparam logic [2:0] OFF_COUNT = 3'd2;
    localparam logic [2:0] OFF_CMP   = 3'd3;
    localparam logic [2:0] OFF_CTRL  = 3'd4;
    localparam logic [2:0] OFF_STAT  = 3'd5;

    logic [31:0] ram [2**RAM_AWIDTH];

    logic [IO_WIDTH-1:0] ledReg, swSync1, swSync2;
    logic [31:0]         count, cmp;
    logic                ctrlEn, match, err;

    logic                  aligned, isRam, isMmio, ramWr, mmioWr, busErr, matchSet;
    logic [RAM_AWIDTH-1:0] ramIdx;
    logic [2:0]            offset;

    assign aligned  = bus.Bus_Address[1:0] == 2'b00;
    assign isRam    = {1'b0, bus.Bus_Address} < RAM_BYTES;
    assign isMmio   = bus.Bus_Address[31:5] == MMIO_BASE[31:5];
    assign ramIdx   = bus.Bus_Address[RAM_AWIDTH+1:2];
    assign offset   = bus.Bus_Address[4:2];
    assign ramWr    = bus.Bus_WriteEnable && aligned && isRam;
    assign mmioWr   = bus.Bus_WriteEnable && aligned && isMmio;
    assign busErr   = bus.Bus_WriteEnable && (!aligned || (!isRam && !isMmio));
    assign matchSet = ctrlEn && (count == cmp);

    // RAM has no reset and keeps committing writes while Reset is held.
    always_ff @(posedge Clock) begin
        if (ramWr) ram[ramIdx] <= bus.Bus_WriteData;
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            ledReg  <= '0;
            swSync1 <= '0;
            swSync2 <= '0;
            count   <= '0;
            cmp     <= 32'hFFFF_FFFF;
            ctrlEn  <= 1'b0;
            match   <= 1'b0;
            err     <= 1'b0;
        end else begin
            swSync1 <= Sw_In;
            swSync2 <= swSync1;
            if (mmioWr && offset == OFF_LED)  ledReg <= bus.Bus_WriteData[IO_WIDTH-1:0];
            if (mmioWr && offset == OFF_CMP)  cmp    <= bus.Bus_WriteData;
            if (mmioWr && offset == OFF_CTRL) ctrlEn <= bus.Bus_WriteData[0];
            // A software COUNT write beats both the increment and the wrap.
            if (mmioWr && offset == OFF_COUNT) count <= bus.Bus_WriteData;
            else if (matchSet)                 count <= '0;
            else if (ctrlEn)                   count <= count + 32'd1;
            // Hardware set wins over a same-cycle W1C.
            match <= matchSet || (match && !(mmioWr && offset == OFF_STAT && bus.Bus_WriteData[0]));
            err   <= busErr   || (err   && !(mmioWr && offset == OFF_STAT && bus.Bus_WriteData[1]));
        end
    end

    always_comb begin
        bus.Bus_ReadData = '0;
        if (aligned) begin
            if (isRam) begin
                bus.Bus_ReadData = ram[ramIdx];
            end else if (isMmio) begin
                case (offset)
                    OFF_LED:   bus.Bus_ReadData = {{(32-IO_WIDTH){1'b0}}, ledReg};
                    OFF_SW:    bus.Bus_ReadData = {{(32-IO_WIDTH){1'b0}}, swSync2};
                    OFF_COUNT: bus.Bus_ReadData = count;
                    OFF_CMP:   bus.Bus_ReadData = cmp;
                    OFF_CTRL:  bus.Bus_ReadData = {31'b0, ctrlEn};
                    OFF_STAT:  bus.Bus_ReadData = {30'b0, err, match};
                    default:   bus.Bus_ReadData = '0;
                endcase
            end
        end
    end

    assign Led_Out   = ledReg;
    assign Timer_Irq = match;
    assign Err_Flag  = err;
endmodule

// File: tb/tb_proc_mem_responder.sv
// Scoreboarded bench for proc_mem_responder: reads push expectations, a negedge monitor pops them.
module tb_proc_mem_responder;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic       Clock = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] Sw_In = '0;
    logic [7:0] Led_Out;
    logic       Timer_Irq, Err_Flag;

    proc_mem_responder_if bus();

    proc_mem_responder dut (
        .Clock(Clock), .Reset(Reset), .bus(bus), .Sw_In(Sw_In),
        .Led_Out(Led_Out), .Timer_Irq(Timer_Irq), .Err_Flag(Err_Flag)
    );

    always #5 Clock = ~Clock;

    int nTests = 0;
    int nFail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] expQ[$];
    string       tagQ[$];
    logic        rdValid = 1'b0;
    logic [31:0] ramMdl [int];

    always @(negedge Clock) begin
        if (rdValid) begin
            if (expQ.size() != 0) chk(tagQ.pop_front(), bus.Bus_ReadData, expQ.pop_front());
            else                  chk("sbUnderflow", 32'(expQ.size()), 32'd1);
        end
    end

    // All tasks start and end at #1 after a rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.Bus_Address = a; bus.Bus_WriteData = d; bus.Bus_WriteEnable = 1'b1;
        @(posedge Clock); #1;
        bus.Bus_WriteEnable = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus.Bus_Address = a; bus.Bus_WriteEnable = 1'b0;
        expQ.push_back(exp); tagQ.push_back(tag);
        rdValid = 1'b1;
        @(posedge Clock); #1;
        rdValid = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.Bus_Address = '0; bus.Bus_WriteData = '0; bus.Bus_WriteEnable = 1'b0;
        tick(2);
        chk("rstLed", 32'(Led_Out), 0);
        chk("rstIrq", 32'(Timer_Irq), 0);
        chk("rstErr", 32'(Err_Flag), 0);
        Reset = 1'b1;
        rd(MB + 32'h0C, 32'hFFFF_FFFF, "rstCmp");
        rd(MB + 32'h08, 0, "rstCount");
        rd(MB + 32'h10, 0, "rstCtrl");

        // RAM persistence across reset, and RAM writes during reset
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10, 32'hDEAD_BEEF, "ramRd");
        Reset = 1'b0;
        wr(32'h20, 32'h0000_1234);
        wr(MB, 32'h77);
        Reset = 1'b1;
        rd(32'h10, 32'hDEAD_BEEF, "ramKeep");
        rd(32'h20, 32'h0000_1234, "ramWrInRst");
        chk("ledWrInRst", 32'(Led_Out), 0);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            a = 32'($urandom_range(64, 1000)) << 2;
            d = $urandom;
            wr(a, d);
            ramMdl[int'(a)] = d;
        end
        foreach (ramMdl[k]) rd(32'(k), ramMdl[k], "ramRand");
        wr(32'hFFC, 32'hCAFE_F00D);
        rd(32'hFFC, 32'hCAFE_F00D, "ramTop");

        // LED and switch synchroniser
        wr(MB, 32'h5A);
        chk("led", 32'(Led_Out), 32'h5A);
        wr(MB, 32'h1234_56A5);
        rd(MB, 32'hA5, "ledRdMask");
        Sw_In = 8'h3C;
        rd(MB + 4, 0, "sw0");
        rd(MB + 4, 0, "sw1");
        rd(MB + 4, 32'h3C, "sw2");
        wr(MB + 4, 0);
        rd(MB + 4, 32'h3C, "swRo");

        // Timer: 0,1,2,3,0 with MATCH on the wrap
        wr(MB + 32'h0C, 3);
        wr(MB + 32'h10, 1);
        rd(MB + 8, 0, "cnt0");
        rd(MB + 8, 1, "cnt1");
        rd(MB + 8, 2, "cnt2");
        chk("irqPre", 32'(Timer_Irq), 0);
        rd(MB + 8, 3, "cnt3");
        chk("irqSet", 32'(Timer_Irq), 1);
        rd(MB + 8, 0, "cntWrap");
        chk("irqSticky", 32'(Timer_Irq), 1);
        wr(MB + 32'h14, 1);                 // count 1->2, clear
        chk("irqClr", 32'(Timer_Irq), 0);
        rd(MB + 32'h14, 0, "statClr");      // count 2->3
        wr(MB + 32'h14, 1);                 // W1C while COUNT==CMP
        chk("irqSetWins", 32'(Timer_Irq), 1);
        wr(MB + 32'h14, 1);                 // count 0->1, clear
        chk("irqClr2", 32'(Timer_Irq), 0);
        tick(2);                            // count = 3
        wr(MB + 8, 100);
        chk("irqCntWr", 32'(Timer_Irq), 1);
        rd(MB + 8, 100, "cntWrWins");

        // Bus errors and reserved offsets
        wr(MB + 32'h18, 32'hFFFF_FFFF);
        chk("errRsvd", 32'(Err_Flag), 0);
        rd(MB + 32'h18, 0, "rsvdRd");
        wr(32'h0, 32'h1111_1111);
        wr(32'h2, 32'hFFFF_FFFF);
        chk("errMisal", 32'(Err_Flag), 1);
        rd(32'h0, 32'h1111_1111, "misalNoWr");
        rd(32'h2, 0, "misalRd");
        wr(MB + 32'h14, 2);
        chk("errClr", 32'(Err_Flag), 0);
        wr(32'h8000_0000, 32'h5555_5555);
        chk("errUnmap", 32'(Err_Flag), 1);
        rd(32'h8000_0000, 0, "unmapRd");
        rd(32'h1000, 0, "ramEndRd");
        rd(MB + 32'h20, 0, "mmioEndRd");
        rd(MB + 32'h14, 3, "statBoth");

        // Reset mid-count
        wr(MB + 8, 57);
        Reset = 1'b0;
        tick(1);
        Reset = 1'b1;
        chk("midRstIrq", 32'(Timer_Irq), 0);
        chk("midRstErr", 32'(Err_Flag), 0);
        chk("midRstLed", 32'(Led_Out), 0);
        rd(MB + 8, 0, "midRstCnt");
        rd(MB + 32'h10, 0, "midRstCtrl");
        rd(MB + 32'h0C, 32'hFFFF_FFFF, "midRstCmp");
        rd(32'hFFC, 32'hCAFE_F00D, "ramAfterRst");

        tick(1);
        chk("sbDrain", 32'(expQ.size()), 0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
